// File: rtl/kpn_join_module.sv
// Two-input KPN join: buffers two token streams in private FIFOs and emits one matched pair per load into a registered output.
// Latency: one edge from the later token of a pair being pushed to out_valid=1; one pair per cycle sustained.
// Backpressure: out_ready=0 holds the output pair stable; each FIFO then fills and drops its inX_ready. Optional KPN_JOIN_LEVEL_EN adds level_1/level_2 ports.

module kpn_join_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_vld,
    output logic                  wr_rdy,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic [ADDR_WIDTH:0]   count
);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  push;

    // Ready comes straight from the registered count, so a same-cycle pop never opens a slot.
    assign wr_rdy = (count != FULL_CNT);
    assign push   = wr_vld && wr_rdy;
    assign rd_dat = mem[rd_ptr];

    // Storage array; no reset needed since pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module kpn_join_module #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in1_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in2_data,
    input  logic                  in2_valid,
    output logic                  in2_ready,
    output logic [DATA_WIDTH-1:0] entry_1,
    output logic [DATA_WIDTH-1:0] entry_2,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef KPN_JOIN_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level_1,
    output logic [ADDR_WIDTH:0]   level_2
`endif
);
    logic [DATA_WIDTH-1:0] head_1;
    logic [DATA_WIDTH-1:0] head_2;
    logic [ADDR_WIDTH:0]   count_1;
    logic [ADDR_WIDTH:0]   count_2;
    logic                  load;

    // Both heads leave together only when each side has a token and the output slot is free or draining.
    assign load = (count_1 != '0) && (count_2 != '0) && (!out_valid || out_ready);

    kpn_join_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_1 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (in1_valid),
        .wr_rdy  (in1_ready),
        .wr_dat  (in1_data),
        .rd_en   (load),
        .rd_dat  (head_1),
        .count   (count_1)
    );

    kpn_join_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo_2 (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_vld  (in2_valid),
        .wr_rdy  (in2_ready),
        .wr_dat  (in2_data),
        .rd_en   (load),
        .rd_dat  (head_2),
        .count   (count_2)
    );

    // Output pair register: load a new pair, drain on acceptance, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_1   <= '0;
            entry_2   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            entry_1   <= head_1;
            entry_2   <= head_2;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef KPN_JOIN_LEVEL_EN
    // FIFO counts are already registers, so they are exported directly.
    assign level_1 = count_1;
    assign level_2 = count_2;
`endif
endmodule

// File: tb/tb_kpn_join_module.sv
module tb_kpn_join_module;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int AW = 2;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] in1_data, in2_data;
    logic          in1_valid, in2_valid;
    logic          in1_ready, in2_ready;
    logic [DW-1:0] entry_1, entry_2;
    logic          out_valid;
    logic          out_ready;
`ifdef KPN_JOIN_LEVEL_EN
    logic [AW:0]   level_1, level_2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    kpn_join_module #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in2_data  (in2_data),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .entry_1   (entry_1),
        .entry_2   (entry_2),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef KPN_JOIN_LEVEL_EN
        ,
        .level_1   (level_1),
        .level_2   (level_2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [DW-1:0] d1,
                         input logic v2, input logic [DW-1:0] d2, input logic ordy);
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, '0, 0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic          v1;
        logic [DW-1:0] d1;
        logic          v2;
        logic [DW-1:0] d2;
        logic          ordy;
        logic          ov;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic          r1;
        logic          r2;
    } vec_t;

    vec_t tbl[10];

    // Reference model state for the randomized phase.
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          m_ov;
    logic [DW-1:0] m_e1, m_e2;

    initial begin
        // Single pair then skewed arrival; expectations hold after each row's edge.
        tbl[0] = '{1'b1, 16'h000A, 1'b1, 16'h0014, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 16'h000F, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 16'h000F, 1'b1, 1'b0, 16'h000A, 16'h0014, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000F, 16'h000F, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h000F, 16'h000F, 1'b1, 1'b1};

        // Reset state.
        do_reset();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_entry_1", 32'(entry_1), 32'd0);
        check("reset_entry_2", 32'(entry_2), 32'd0);
        check("reset_in1_ready", 32'(in1_ready), 32'd1);
        check("reset_in2_ready", 32'(in2_ready), 32'd1);
`ifdef KPN_JOIN_LEVEL_EN
        check("reset_level_1", 32'(level_1), 32'd0);
        check("reset_level_2", 32'(level_2), 32'd0);
`endif

        // Table-driven single pair and skewed arrival.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
            step();
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_entry_1", i), 32'(entry_1), 32'(tbl[i].e1));
            check($sformatf("tbl%0d_entry_2", i), 32'(entry_2), 32'(tbl[i].e2));
            check($sformatf("tbl%0d_in1_ready", i), 32'(in1_ready), 32'(tbl[i].r1));
            check($sformatf("tbl%0d_in2_ready", i), 32'(in2_ready), 32'(tbl[i].r2));
        end

        // Fill and back-pressure: five tokens per stream with the output stalled.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, DW'(i), 1'b1, DW'(i), 1'b0);
            step();
        end
        drive(0, '0, 0, '0, 1'b0);
        check("fill_out_valid", 32'(out_valid), 32'd1);
        check("fill_entry_1", 32'(entry_1), 32'd1);
        check("fill_entry_2", 32'(entry_2), 32'd1);
        check("fill_in1_ready", 32'(in1_ready), 32'd0);
        check("fill_in2_ready", 32'(in2_ready), 32'd0);
`ifdef KPN_JOIN_LEVEL_EN
        check("fill_level_1", 32'(level_1), 32'd4);
        check("fill_level_2", 32'(level_2), 32'd4);
`endif
        step();
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_entry_1", 32'(entry_1), 32'd1);
        check("stall_hold_in1_ready", 32'(in1_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            step();
            check($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("drain%0d_entry_1", i), 32'(entry_1), 32'(i));
            check($sformatf("drain%0d_entry_2", i), 32'(entry_2), 32'(i));
            check($sformatf("drain%0d_in1_ready", i), 32'(in1_ready), 32'd1);
        end
        step();
        check("drain_end_valid", 32'(out_valid), 32'd0);

        // Streaming: one pair per cycle with no bubbles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, DW'(i), 1'b1, DW'(i), 1'b1);
            else       drive(0, '0, 0, '0, 1'b1);
            step();
            if (i >= 1 && i <= 8) begin
                check($sformatf("stream%0d_valid", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("stream%0d_entry_1", i - 1), 32'(entry_1), 32'(i - 1));
                check($sformatf("stream%0d_entry_2", i - 1), 32'(entry_2), 32'(i - 1));
            end
        end
        check("stream_end_valid", 32'(out_valid), 32'd0);

        // Reset mid-operation: one pair held, three tokens buffered per side.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(16'h21 + i), 1'b1, DW'(16'h31 + i), 1'b0);
            step();
        end
        drive(0, '0, 0, '0, 1'b0);
        check("preRst_valid", 32'(out_valid), 32'd1);
        check("preRst_entry_1", 32'(entry_1), 32'h21);
        check("preRst_entry_2", 32'(entry_2), 32'h31);
        #1 reset_n = 1'b0;
        #1;
        check("asyncRst_valid", 32'(out_valid), 32'd0);
        check("asyncRst_entry_1", 32'(entry_1), 32'd0);
        check("asyncRst_entry_2", 32'(entry_2), 32'd0);
        check("asyncRst_in1_ready", 32'(in1_ready), 32'd1);
`ifdef KPN_JOIN_LEVEL_EN
        check("asyncRst_level_1", 32'(level_1), 32'd0);
`endif
        #1 reset_n = 1'b1;
        drive(1'b1, 16'h000A, 1'b1, 16'h000A, 1'b1);
        step();
        drive(0, '0, 0, '0, 1'b1);
        check("postRst_push_valid", 32'(out_valid), 32'd0);
        step();
        check("postRst_pair_valid", 32'(out_valid), 32'd1);
        check("postRst_entry_1", 32'(entry_1), 32'h000A);
        check("postRst_entry_2", 32'(entry_2), 32'h000A);
        step();
        check("postRst_no_stale", 32'(out_valid), 32'd0);
        step();
        check("postRst_no_stale2", 32'(out_valid), 32'd0);

        // Randomized traffic against a queue-level model of the join.
        do_reset();
        q1.delete();
        q2.delete();
        m_ov = 1'b0;
        m_e1 = '0;
        m_e2 = '0;
        for (int c = 0; c < 400; c++) begin
            logic          v1, v2, ordy, acc1, acc2, take;
            logic [DW-1:0] d1, d2;
            check("rnd_in1_ready", 32'(in1_ready), 32'(q1.size() < DEPTH));
            check("rnd_in2_ready", 32'(in2_ready), 32'(q2.size() < DEPTH));
            v1   = ($urandom_range(0, 99) < 60);
            v2   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 65);
            d1   = DW'($urandom);
            d2   = DW'($urandom);
            drive(v1, d1, v2, d2, ordy);
            acc1 = v1 && (q1.size() < DEPTH);
            acc2 = v2 && (q2.size() < DEPTH);
            take = (q1.size() > 0) && (q2.size() > 0) && (!m_ov || ordy);
            if (take) begin
                m_e1 = q1.pop_front();
                m_e2 = q2.pop_front();
                m_ov = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (acc1) q1.push_back(d1);
            if (acc2) q2.push_back(d2);
            step();
            check("rnd_out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                check("rnd_entry_1", 32'(entry_1), 32'(m_e1));
                check("rnd_entry_2", 32'(entry_2), 32'(m_e2));
            end
`ifdef KPN_JOIN_LEVEL_EN
            check("rnd_level_1", 32'(level_1), 32'(q1.size()));
            check("rnd_level_2", 32'(level_2), 32'(q2.size()));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
